// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator behind a 2-entry skid buffer.
// Each accepted instruction is decoded into its sign-extended immediate and
// the pc-relative target (pc + imm), then held in a main/skid register pair
// so that in_ready is registered and does not depend on out_ready.
// Optional feature macro: IMMGEN_ILLEGAL_DETECT_EN (illegal opcode flag).
module imm_gen_pipe #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CLEARS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_immext,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [31:0]       r_main_instr;
    logic [XLEN-1:0]   r_main_imm;
    logic [XLEN-1:0]   r_main_tgt;
    logic [31:0]       r_skid_instr;
    logic [XLEN-1:0]   r_skid_imm;
    logic [XLEN-1:0]   r_skid_tgt;
    logic [XLEN-1:0]   w_imm;
    logic [XLEN-1:0]   w_target;
    logic [2:0]        w_funct3;
    logic              w_accept;
    logic              w_deliver;
    logic              w_flush;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_move_skid;

    assign w_funct3  = in_instr[14:12];
    assign w_accept  = in_valid && r_in_ready;
    assign w_deliver = r_out_valid && out_ready;
    assign w_flush   = (FLUSH_CLEARS != 0) && flush;
    assign w_target  = in_pc + w_imm;

    // Decode the immediate of the incoming instruction; unknown opcodes give 0.
    always_comb begin
        w_imm = {XLEN{1'b0}};
        case (in_instr[6:0])
            7'b0000011, 7'b1100111: begin
                w_imm = XLEN'($signed(in_instr[31:20]));
            end
            7'b0010011: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    if (XLEN == 64) begin
                        w_imm = XLEN'(in_instr[25:20]);
                    end else begin
                        w_imm = XLEN'(in_instr[24:20]);
                    end
                end else begin
                    w_imm = XLEN'($signed(in_instr[31:20]));
                end
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                        w_imm = XLEN'(in_instr[24:20]);
                    end else begin
                        w_imm = XLEN'($signed(in_instr[31:20]));
                    end
                end else begin
                    w_imm = {XLEN{1'b0}};
                end
            end
            7'b0100011: begin
                w_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            end
            7'b1100011: begin
                w_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                       in_instr[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                w_imm = XLEN'($signed({in_instr[31:12], 12'h000}));
            end
            7'b1101111: begin
                w_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                       in_instr[30:21], 1'b0}));
            end
            default: begin
                w_imm = {XLEN{1'b0}};
            end
        endcase
    end

    // Next-state and register-load selection for the skid buffer.
    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_move_skid = 1'b0;
        if (w_flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_load_main = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_deliver) begin
                        w_state_nxt = ST_ONE;
                        w_load_main = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_deliver) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_deliver) begin
                        w_state_nxt = ST_ONE;
                        w_move_skid = 1'b1;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State register with registered handshake outputs derived from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Main and skid data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_instr <= 32'h0000_0000;
            r_main_imm   <= {XLEN{1'b0}};
            r_main_tgt   <= {XLEN{1'b0}};
            r_skid_instr <= 32'h0000_0000;
            r_skid_imm   <= {XLEN{1'b0}};
            r_skid_tgt   <= {XLEN{1'b0}};
        end else begin
            if (w_load_main) begin
                r_main_instr <= in_instr;
                r_main_imm   <= w_imm;
                r_main_tgt   <= w_target;
            end else if (w_move_skid) begin
                r_main_instr <= r_skid_instr;
                r_main_imm   <= r_skid_imm;
                r_main_tgt   <= r_skid_tgt;
            end
            if (w_load_skid) begin
                r_skid_instr <= in_instr;
                r_skid_imm   <= w_imm;
                r_skid_tgt   <= w_target;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_instr  = r_main_instr;
    assign out_immext = r_main_imm;
    assign out_target = r_main_tgt;

`ifdef IMMGEN_ILLEGAL_DETECT_EN
    logic w_known;
    logic w_illegal;
    logic r_main_ill;
    logic r_skid_ill;

    // Flag opcodes outside the decoded set (op-imm-32 only exists for XLEN=64).
    always_comb begin
        w_known = 1'b0;
        case (in_instr[6:0])
            7'b0000011, 7'b1100111, 7'b0010011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111: begin
                w_known = 1'b1;
            end
            7'b0011011: begin
                w_known = (XLEN == 64);
            end
            default: begin
                w_known = 1'b0;
            end
        endcase
        w_illegal = !w_known || (in_instr[1:0] != 2'b11);
    end

    // Illegal flag travels with its entry through main/skid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_ill <= 1'b0;
            r_skid_ill <= 1'b0;
        end else begin
            if (w_load_main) begin
                r_main_ill <= w_illegal;
            end else if (w_move_skid) begin
                r_main_ill <= r_skid_ill;
            end
            if (w_load_skid) begin
                r_skid_ill <= w_illegal;
            end
        end
    end

    assign out_illegal = r_main_ill;
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus
// stream; a queue-based model predicts every output on every cycle.
module tb_imm_gen_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [63:0] in_pc64;
    logic        flush;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_instr32, out_immext32, out_target32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [31:0] out_instr64;
    logic [63:0] out_immext64, out_target64;

    int n_checks;
    int n_errors;

    assign in_pc64 = {32'h0000_0000, in_pc};

    imm_gen_pipe #(.XLEN(32), .FLUSH_CLEARS(1)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid32), .out_ready(out_ready), .out_instr(out_instr32),
        .out_immext(out_immext32), .out_target(out_target32),
        .out_illegal(out_illegal32)
    );

    imm_gen_pipe #(.XLEN(64), .FLUSH_CLEARS(1)) u_dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc64), .flush(flush),
        .out_valid(out_valid64), .out_ready(out_ready), .out_instr(out_instr64),
        .out_immext(out_immext64), .out_target(out_target64),
        .out_illegal(out_illegal64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Immediate as defined by the ISA field placement, built arithmetically.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int xlen);
        logic [63:0]        w;
        logic signed [63:0] ss;
        logic [63:0]        t20, t19, t11;
        logic [2:0]         f3;
        logic [63:0]        r;
        w   = {32'h0000_0000, ins};
        ss  = {{32{ins[31]}}, ins};
        t20 = ss >>> 20;
        t19 = ss >>> 19;
        t11 = ss >>> 11;
        f3  = ins[14:12];
        case (ins[6:0])
            7'h03, 7'h67: r = t20;
            7'h13: r = (f3 == 3'd1 || f3 == 3'd5) ?
                       ((w >> 20) & ((xlen == 64) ? 64'h3F : 64'h1F)) : t20;
            7'h1B: r = (xlen != 64) ? 64'h0 :
                       ((f3 == 3'd1 || f3 == 3'd5) ? ((w >> 20) & 64'h1F) : t20);
            7'h23: r = (t20 & ~64'h1F) | ((w >> 7) & 64'h1F);
            7'h63: r = (t19 & ~64'hFFF) | (((w >> 7) & 64'h1) << 11) |
                       (((w >> 25) & 64'h3F) << 5) | (((w >> 8) & 64'hF) << 1);
            7'h37, 7'h17: r = ss & ~64'hFFF;
            7'h6F: r = (t11 & ~64'hFFFFF) | (w & 64'hFF000) |
                       (((w >> 20) & 64'h1) << 11) | (((w >> 21) & 64'h3FF) << 1);
            default: r = 64'h0;
        endcase
        if (xlen == 32) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    function automatic logic ref_ill(input logic [31:0] ins, input int xlen);
        logic known;
        case (ins[6:0])
            7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F: known = 1'b1;
            7'h1B: known = (xlen == 64);
            default: known = 1'b0;
        endcase
`ifdef IMMGEN_ILLEGAL_DETECT_EN
        return !known || (ins[1:0] != 2'b11);
`else
        return known && 1'b0;
`endif
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [31:0] tgt32;
        logic [63:0] imm64;
        logic [63:0] tgt64;
        logic        ill32;
        logic        ill64;
    } exp_t;

    exp_t mq[$];
    bit   m_acc;

    function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [63:0] i32;
        logic [63:0] t32;
        i32     = ref_imm(ins, 32);
        t32     = {32'h0, pc} + i32;
        e.instr = ins;
        e.imm32 = i32[31:0];
        e.tgt32 = t32[31:0];
        e.imm64 = ref_imm(ins, 64);
        e.tgt64 = {32'h0, pc} + e.imm64;
        e.ill32 = ref_ill(ins, 32);
        e.ill64 = ref_ill(ins, 64);
        return e;
    endfunction

    // Model: FIFO of at most two entries; ready while fewer than two held.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_acc <= 1'b0;
        end else begin
            m_acc <= !flush && in_valid && (mq.size() < 2);
            if (flush) begin
                mq.delete();
            end else if (mq.size() == 0) begin
                if (in_valid) mq.push_back(mk(in_instr, in_pc));
            end else if (mq.size() == 1) begin
                if (out_ready) void'(mq.pop_front());
                if (in_valid) mq.push_back(mk(in_instr, in_pc));
            end else begin
                if (out_ready) void'(mq.pop_front());
            end
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            check("out_valid32", {63'h0, out_valid32}, {63'h0, mq.size() > 0});
            check("out_valid64", {63'h0, out_valid64}, {63'h0, mq.size() > 0});
            check("in_ready32", {63'h0, in_ready32}, {63'h0, mq.size() < 2});
            check("in_ready64", {63'h0, in_ready64}, {63'h0, mq.size() < 2});
            if (mq.size() > 0) begin
                check("instr32", {32'h0, out_instr32}, {32'h0, mq[0].instr});
                check("imm32", {32'h0, out_immext32}, {32'h0, mq[0].imm32});
                check("tgt32", {32'h0, out_target32}, {32'h0, mq[0].tgt32});
                check("ill32", {63'h0, out_illegal32}, {63'h0, mq[0].ill32});
                check("instr64", {32'h0, out_instr64}, {32'h0, mq[0].instr});
                check("imm64", out_immext64, mq[0].imm64);
                check("tgt64", out_target64, mq[0].tgt64);
                check("ill64", {63'h0, out_illegal64}, {63'h0, mq[0].ill64});
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vec [16] = '{
        32'hFFF00093, 32'h03F01093, 32'h4030D093, 32'hFFC12083,
        32'hFE112E23, 32'hFE000EE3, 32'h0080006F, 32'h123450B7,
        32'h80000097, 32'hFFC080E7, 32'h0000007F, 32'hFFF0809B,
        32'h01F0909B, 32'h00000010, 32'h7FF00013, 32'h8000006F
    };

    initial begin
        bit got;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Hand-computed values pinning the model.
        check("model_addi", ref_imm(32'hFFF00093, 32), 64'hFFFF_FFFF);
        check("model_slli64", ref_imm(32'h03F01093, 64), 64'h3F);
        check("model_slli32", ref_imm(32'h03F01093, 32), 64'h1F);
        check("model_beq", ref_imm(32'hFE000EE3, 64), 64'hFFFF_FFFF_FFFF_FFFC);
        check("model_jal", ref_imm(32'h0080006F, 32), 64'h8);
        check("model_lui", ref_imm(32'h123450B7, 32), 64'h1234_5000);
        check("model_sw", ref_imm(32'hFE112E23, 32), 64'hFFFF_FFFC);

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {63'h0, out_valid32}, 64'h0);
        check("rst_ready", {63'h0, in_ready32}, 64'h1);
        check("rst_instr", {32'h0, out_instr32}, 64'h0);
        check("rst_imm64", out_immext64, 64'h0);
        reset = 1'b0;

        cyc(1'b1, 32'hFFF00093, 32'h0000_0100, 1'b1, 1'b0);
        check("addi_valid", {63'h0, out_valid32}, 64'h1);
        check("addi_imm", {32'h0, out_immext32}, 64'hFFFF_FFFF);
        check("addi_tgt", {32'h0, out_target32}, 64'hFF);
        cyc(1'b1, 32'h03F01093, 32'h0000_0200, 1'b1, 1'b0);
        check("slli_imm64", out_immext64, 64'h3F);
        check("slli_imm32", {32'h0, out_immext32}, 64'h1F);
        cyc(1'b1, 32'h0000007F, 32'h0000_0300, 1'b1, 1'b0);
`ifdef IMMGEN_ILLEGAL_DETECT_EN
        check("ill_flag", {63'h0, out_illegal32}, 64'h1);
`else
        check("ill_flag", {63'h0, out_illegal32}, 64'h0);
`endif
        check("ill_imm", {32'h0, out_immext32}, 64'h0);
        check("ill_tgt", {32'h0, out_target32}, 64'h300);

        // Streamed table, including a wrap-around target at the top of memory.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, vec[i], 32'h0000_1000 + 32'(i * 4), 1'b1, 1'b0);
        end
        cyc(1'b1, 32'h0080006F, 32'hFFFF_FFF8, 1'b1, 1'b0);
        check("wrap_tgt32", {32'h0, out_target32}, 64'h0);
        check("wrap_tgt64", out_target64, 64'h1_0000_0000);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: A, B accepted, C held off until the buffer drains.
        cyc(1'b1, 32'hFFF00093, 32'h0000_2000, 1'b0, 1'b0);
        cyc(1'b1, 32'h0080006F, 32'h0000_2004, 1'b0, 1'b0);
        check("bp_ready", {63'h0, in_ready32}, 64'h0);
        cyc(1'b1, 32'h123450B7, 32'h0000_2008, 1'b0, 1'b0);
        cyc(1'b1, 32'h123450B7, 32'h0000_2008, 1'b0, 1'b0);
        check("bp_head", {32'h0, out_instr32}, 64'hFFF00093);
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            cyc(1'b1, 32'h123450B7, 32'h0000_2008, 1'b1, 1'b0);
            got = m_acc;
        end
        check("bp_c_accepted", {63'h0, got}, 64'h1);
        repeat (4) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while full with a simultaneous offer.
        cyc(1'b1, 32'hFE112E23, 32'h0000_3000, 1'b0, 1'b0);
        cyc(1'b1, 32'hFE000EE3, 32'h0000_3004, 1'b0, 1'b0);
        cyc(1'b1, 32'h4030D093, 32'h0000_3008, 1'b0, 1'b1);
        check("flush_valid", {63'h0, out_valid32}, 64'h0);
        check("flush_ready", {63'h0, in_ready32}, 64'h1);
        repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Reset while full takes effect before the next edge.
        cyc(1'b1, 32'hFFC12083, 32'h0000_4000, 1'b0, 1'b0);
        cyc(1'b1, 32'hFFC080E7, 32'h0000_4004, 1'b0, 1'b0);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("arst_valid", {63'h0, out_valid32}, 64'h0);
        check("arst_ready", {63'h0, in_ready32}, 64'h1);
        check("arst_instr", {32'h0, out_instr32}, 64'h0);
        check("arst_tgt64", out_target64, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b1, 32'h80000097, 32'h0000_5000, 1'b1, 1'b0);
        check("post_rst_imm", {32'h0, out_immext32}, 64'h8000_0000);
        repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter FLUSH_CLEARS, default 1, meaning flush empties held entries (0 = flush ignored).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an instruction this cycle.
REQ-007 SHALL have port in_instr  input  32  raw RISC-V instruction word.
REQ-008 SHALL have port in_pc  input  XLEN  instruction address.
REQ-009 SHALL have port flush  input  1  discard all held entries.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_instr  output  32  instruction passed through.
REQ-013 SHALL have port out_immext  output  XLEN  extended immediate.
REQ-014 SHALL have port out_target  output  XLEN  in_pc + immext, modulo 2^XLEN.
REQ-015 SHALL have port out_illegal  output  1  unrecognised opcode flag (see Configuration).

Function
REQ-016 SHALL be a 2-entry skid buffer: main register plus skid register, each holding instr, immext, target, illegal, valid bit.
REQ-017 SHALL compute immext and target combinationally from in_instr/in_pc and register them on acceptance; latency 1 cycle from accept to out_valid.
REQ-018 Accept SHALL occur when in_valid && in_ready; deliver SHALL occur when out_valid && out_ready.
REQ-019 in_ready SHALL be registered and equal "skid entry empty"; it SHALL not depend combinationally on out_ready.
REQ-020 States: EMPTY (no entry), ONE (main valid), FULL (main+skid valid); out_valid = main valid.
REQ-021 EMPTY: accept -> ONE. ONE: accept without deliver -> FULL; accept with deliver -> ONE (new data in main); deliver only -> EMPTY. FULL: deliver -> ONE with skid moved to main; no accept possible.
REQ-022 Output ordering SHALL be strictly FIFO; no entry dropped or duplicated under back-pressure.
REQ-023 Immediate formats: I (load 0000011, jalr 1100111, op-imm 0010011), S (0100011), B (1100011), U (lui 0110111, auipc 0010111), J (1101111), all sign-extended from instr[31] to XLEN; B and J bit0 = 0; U low 12 bits = 0.
REQ-024 op-imm funct3 001/101: immext = zero-extended shamt, instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-025 XLEN=64 only: opcode 0011011 (op-imm-32) SHALL decode as I-type, with funct3 001/101 giving zero-extended instr[24:20]; when XLEN=32 it is unrecognised.
REQ-026 Unrecognised opcode: immext = 0, target = in_pc.
REQ-027 flush with FLUSH_CLEARS=1 SHALL clear both valid bits at the clock edge; a simultaneous accept SHALL be discarded; in_ready = 1 next cycle.
REQ-028 Data registers SHALL hold value while their valid bit is 0 only as don't-care; outputs are qualified by out_valid.

Reset
REQ-029 reset asserted SHALL immediately force state EMPTY, out_valid = 0, in_ready = 1, out_instr/out_immext/out_target = 0, out_illegal = 0.
REQ-030 reset mid-transfer SHALL discard all held entries; first accept after deassert behaves as from EMPTY.

Configuration
REQ-031 Macro IMMGEN_ILLEGAL_DETECT_EN: when defined, out_illegal = 1 for an entry whose opcode is unrecognised per REQ-023/025 or whose instr[1:0] != 2'b11; when undefined, out_illegal SHALL be constant 0 and no detection logic built.

Verification
REQ-032 XLEN=32, in_instr=32'hFFF00093 (addi -1), in_pc=32'h100, out_ready=1 -> next cycle out_valid=1, out_immext=32'hFFFFFFFF, out_target=32'hFF.
REQ-033 XLEN=64, slli shamt 63 (32'h03F01093) -> out_immext=64'h3F; same word at XLEN=32 -> 64-bit check n/a, out_immext=32'h1F.
REQ-034 out_ready=0, three consecutive in_valid beats A,B,C -> A,B accepted, in_ready=0 for C; raise out_ready -> A then B then C in order, none lost.
REQ-035 FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle input not delivered.
REQ-036 With IMMGEN_ILLEGAL_DETECT_EN, in_instr=32'h0000007F -> out_illegal=1, out_immext=0, out_target=in_pc; without macro -> out_illegal=0.
REQ-037 Assert reset while FULL -> out_valid=0 and in_ready=1 before next clk edge.
